// File: rtl/lsu_byte_seq_if.sv
// Request/response bundle between the pipeline memory stage and the byte sequencer.
interface lsu_byte_seq_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_err_o;
    logic [31:0]       rsp_rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// Serialises byte/half/word loads and stores into little-endian byte cycles on an
// 8-bit RAM port with combinational read, returning extended load data.
module lsu_byte_seq #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    lsu_byte_seq_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wren_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              req_bad_c;
    logic [1:0]        last_c;
    logic [31:0]       raw_c;

    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                           input logic [31:0] raw);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Alignment / legality of the incoming request
    always_comb begin
        req_bad_c = 1'b0;
        case (bus.req_size_i)
            2'b01:   req_bad_c = bus.req_addr_i[0];
            2'b10:   req_bad_c = |bus.req_addr_i[1:0];
            2'b11:   req_bad_c = 1'b1;
            default: req_bad_c = 1'b0;
        endcase
    end

    always_comb begin
        last_c = 2'd3;
        case (size_q)
            2'b00:   last_c = 2'd0;
            2'b01:   last_c = 2'd1;
            default: last_c = 2'd3;
        endcase
    end

    // Load buffer with the current RAM byte merged into its lane
    always_comb begin
        raw_c = buf_q;
        raw_c[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            buf_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q        <= bus.req_we_i;
                        size_q      <= bus.req_size_i;
                        uns_q       <= bus.req_unsigned_i;
                        addr_q      <= bus.req_addr_i;
                        wdata_q     <= bus.req_wdata_i;
                        cnt_q       <= 2'd0;
                        buf_q       <= 32'h0;
                        rsp_rdata_q <= 32'h0;
                        if (req_bad_c) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    buf_q <= raw_c;
                    if (cnt_q == last_c) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : extend(size_q, uns_q, raw_c);
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

    // RAM port; write enable gated by reset so an aborting edge never writes
    always_comb begin
        mem_addr_o  = '0;
        mem_wren_o  = 1'b0;
        mem_wdata_o = 8'h00;
        if (state_q == ACCESS) begin
            mem_addr_o  = addr_q + ADDR_W'(cnt_q);
            mem_wren_o  = we_q & rst_ni;
            mem_wdata_o = we_q ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
        end
    end
endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq: directed vector table, reset-abort sequence
// and random traffic against a byte-array memory model.
module tb_lsu_byte_seq;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk_i;
    logic              rst_ni;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic [7:0] ram     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    int errors;
    int checks;

    lsu_byte_seq_if #(.ADDR_W(ADDR_W)) bif ();

    lsu_byte_seq #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bif.slave),
        .mem_addr_o  (mem_addr),
        .mem_wren_o  (mem_wren),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk_i) if (mem_wren) ram[mem_addr] <= mem_wdata;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [1:0] sz, input logic [12:0] a);
        int ai;
        ai = int'(a);
        return (sz == 2'b11) || (sz == 2'b01 && ai % 2 != 0) || (sz == 2'b10 && ai % 4 != 0);
    endfunction

    function automatic int ref_len(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian assembly and two's-complement extension by arithmetic
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [12:0] a);
        longint v;
        int nb;
        nb = ref_len(sz);
        v  = 0;
        for (int i = 0; i < nb; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        return 32'(v);
    endfunction

    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [12:0] a, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd, input string nm);
        int n;
        int wr_cnt;
        n = exp_err ? 0 : ref_len(sz);
        @(negedge clk_i);
        bif.req_valid_i    = 1'b1;
        bif.req_we_i       = we;
        bif.req_size_i     = sz;
        bif.req_unsigned_i = uns;
        bif.req_addr_i     = a;
        bif.req_wdata_i    = wd;
        @(posedge clk_i);
        #1;
        bif.req_valid_i    = 1'b0;
        bif.req_we_i       = 1'($urandom);
        bif.req_size_i     = 2'($urandom);
        bif.req_addr_i     = 13'($urandom);
        bif.req_wdata_i    = $urandom;
        chk({nm, "_busy_ready"}, 32'(bif.req_ready_o), 32'd0);
        wr_cnt = 0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk_i);
                #1;
            end
            if (mem_wren) wr_cnt++;
            if (k == 0 && !exp_err) chk({nm, "_rdata_clr"}, bif.rsp_rdata_o, 32'h0);
            if (k < n) chk({nm, "_early_valid"}, 32'(bif.rsp_valid_o), 32'd0);
        end
        chk({nm, "_valid"}, 32'(bif.rsp_valid_o), 32'd1);
        chk({nm, "_err"}, 32'(bif.rsp_err_o), 32'(exp_err));
        chk({nm, "_rdata"}, bif.rsp_rdata_o, exp_rd);
        chk({nm, "_wr_cycles"}, 32'(wr_cnt), (we && !exp_err) ? 32'(n) : 32'd0);
        if (we && !exp_err)
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        @(posedge clk_i);
        #1;
        chk({nm, "_ready_after"}, {31'd0, bif.req_ready_o}, 32'd1);
        chk({nm, "_valid_pulse"}, {31'd0, bif.rsp_valid_o}, 32'd0);
        chk({nm, "_rdata_hold"}, bif.rsp_rdata_o, exp_rd);
    endtask

    initial begin
        int bad;
        logic        r_we;
        logic [1:0]  r_sz;
        logic        r_uns;
        logic [12:0] r_a;
        logic [31:0] r_wd;
        logic        r_err;

        errors = 0;
        checks = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bif.req_valid_i    = 1'b0;
        bif.req_we_i       = 1'b0;
        bif.req_size_i     = 2'b00;
        bif.req_unsigned_i = 1'b0;
        bif.req_addr_i     = '0;
        bif.req_wdata_i    = 32'h0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(bif.req_ready_o), 32'd1);
        chk("rst_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("rst_err", 32'(bif.rsp_err_o), 32'd0);
        chk("rst_rdata", bif.rsp_rdata_o, 32'h0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 13'h0010, 32'hA1B2C3D4, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 13'h0013, 32'h0,        1'b0, 32'hFFFFFFA1};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 13'h0013, 32'h0,        1'b0, 32'h000000A1};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 13'h0012, 32'h0,        1'b0, 32'hFFFFA1B2};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 13'h0010, 32'h0,        1'b0, 32'hA1B2C3D4};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 13'h0011, 32'hDEADBEEF, 1'b1, 32'h00000000};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 13'h0001, 32'h00001234, 1'b1, 32'h00000000};
        vecs[7]  = '{1'b1, 2'b11, 1'b0, 13'h0000, 32'h00000055, 1'b1, 32'h00000000};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 13'h0010, 32'h0,        1'b0, 32'hFFFFC3D4};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 13'h1FFC, 32'h55667788, 1'b0, 32'h00000000};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0,        1'b0, 32'h55667788};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 13'h1FFE, 32'h0,        1'b0, 32'h00005566};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 13'h1FFC, 32'h0,        1'b0, 32'hFFFFFF88};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 13'h0000, 32'h0,        1'b0, 32'h00000000};

        foreach (vecs[i])
            run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        chk("wrap_guard_low", 32'(ram[0]), 32'h0);

        // Reset during the third byte of a word store
        ram[13'h40] = 8'h11; ram[13'h41] = 8'h22; ram[13'h42] = 8'h33; ram[13'h43] = 8'h44;
        ref_mem[13'h40] = 8'h11; ref_mem[13'h41] = 8'h22;
        ref_mem[13'h42] = 8'h33; ref_mem[13'h43] = 8'h44;
        @(negedge clk_i);
        bif.req_valid_i = 1'b1;
        bif.req_we_i    = 1'b1;
        bif.req_size_i  = 2'b10;
        bif.req_addr_i  = 13'h0040;
        bif.req_wdata_i = 32'hCAFEBABE;
        @(posedge clk_i);
        #1;
        bif.req_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("abort_wren_gated", 32'(mem_wren), 32'd0);
        @(posedge clk_i);
        #1;
        chk("abort_ready", 32'(bif.req_ready_o), 32'd1);
        chk("abort_valid", 32'(bif.rsp_valid_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk_i);
            #1;
            if (bif.rsp_valid_o) bad++;
        end
        chk("abort_no_rsp", 32'(bad), 32'd0);
        ref_mem[13'h40] = 8'hBE;
        ref_mem[13'h41] = 8'hBA;
        chk("abort_bytes", {ram[13'h40], ram[13'h41], ram[13'h42], ram[13'h43]},
            32'hBEBA3344);

        // Random traffic near both ends of the address space
        for (int t = 0; t < 300; t++) begin
            r_we  = 1'($urandom);
            r_sz  = 2'($urandom);
            r_uns = 1'($urandom);
            r_a   = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 31))
                                                : 13'($urandom_range(8160, 8191));
            r_wd  = $urandom;
            r_err = ref_bad(r_sz, r_a);
            run_req(r_we, r_sz, r_uns, r_a, r_wd, r_err,
                    (r_we || r_err) ? 32'h0 : ref_load(r_sz, r_uns, r_a), "rnd");
        end

        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
